acc_core: RTL
=============

Name: acc_core

Overview:
- DUT-side accumulator that the testbench drives through the clocking block on the same a/b/acc/acc_en_n/rst_n/y signal set.
- Each enabled clock edge it either loads a fresh sum a+b or adds a to the running result.
- Also keeps a sticky unsigned-overflow flag and a count of terms accumulated since the last load.
- Sits directly under the accumulator testbench top; it is the block the scoreboard model checks.

Parameters:
- WIDTH, 32, data width of a, b, y (matches acc_pkg data_t).
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  first addend, unsigned.
- b  input  WIDTH  second addend, used only when acc=0.
- acc  input  1  1 = accumulate (y+a), 0 = load (a+b).
- acc_en_n  input  1  active-low register enable; 1 = hold all state.
- y  output  WIDTH  registered result.
- ovf  output  1  sticky overflow since last load.
- cnt  output  CNT_W  number of terms in current result.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): y=0, ovf=0, cnt=0, state=EMPTY. This holds regardless of clk, including mid-accumulation. The first edge after deassertion operates normally.
- Latency: one cycle. Inputs sampled at edge k appear on y after edge k; y is never combinational from inputs.
- acc_en_n=1: y, ovf, cnt and state all hold; a, b, acc are ignored.
- Operand select: addend2 = acc ? y : b. Sum is computed at WIDTH+1 bits, and carry = sum[WIDTH].
- FSM states: EMPTY (no load since reset), LOADED (result valid).
  - EMPTY, enabled, acc=0 -> LOADED: y=a+b, ovf=carry, cnt=2.
  - EMPTY, enabled, acc=1 -> LOADED: y=0+a=a, ovf=0, cnt=1. This is legal, since y is 0 after reset.
  - LOADED, enabled, acc=0: reload with y=a+b, ovf=carry (sticky value cleared first), cnt=2.
  - LOADED, enabled, acc=1: y=y+a, ovf=ovf|carry, cnt=cnt+1, saturating at 2^CNT_W-1 (no wrap).
- Arithmetic is unsigned. Without the optional feature, y wraps modulo 2^WIDTH.
- No X propagation: when acc=1, b is don't-care and an X on b must not reach y.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: any operation with carry=1 sets y to all-ones (2^WIDTH-1) instead of the wrapped value. Subsequent accumulates that carry stay at all-ones. ovf and cnt behave as without the macro.
- Undefined: y wraps modulo 2^WIDTH, and no saturation logic is synthesised.

Test Plan:
Test Plan scenarios use WIDTH=8.
- Reset then a=3, b=4, acc=0, acc_en_n=0 for one edge -> y=7, ovf=0, cnt=2 after that edge.
- Then acc=1 with a=10, then a=5, on two enabled edges -> y=17, then y=22; cnt=3, then 4; b=X has no effect.
- y=250 (LOADED), acc=1, a=10 -> without ACC_SAT_EN: y=4, ovf=1. With ACC_SAT_EN: y=255, ovf=1. A following load a=1, b=1 -> y=2, ovf=0.
- acc_en_n=1 for 5 edges with random a, b, acc -> y, ovf, cnt unchanged from the prior value.
- rst_n pulsed low between edges while y=22, cnt=4 -> y=0, cnt=0, ovf=0 immediately, before the next edge. The next enabled acc=1, a=9 edge -> y=9, cnt=1.
- CNT_W=2: load, then 4 accumulate edges -> cnt sequence 2, 3, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/acc_core.sv
// Registered accumulator: load a+b or accumulate y+a, with sticky overflow and a saturating term count.
// Optional macro ACC_SAT_EN clamps y to all-ones on any carry instead of wrapping.
module acc_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc,
  input  logic             acc_en_n,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] addend2;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] result;

  // b is only selected on a load, so an X on b cannot leak into an accumulate.
  assign addend2 = acc ? ((state_reg == LOADED) ? y_reg : '0) : b;
  assign sum     = {1'b0, a} + {1'b0, addend2};
  assign carry   = sum[WIDTH];

`ifdef ACC_SAT_EN
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sat
      assign result[gi] = sum[gi] | carry;
    end
  endgenerate
`else
  assign result = sum[WIDTH-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    if (!acc_en_n) begin
      state_next = LOADED;
      y_next     = result;
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            ovf_next = 1'b0;
            cnt_next = CNT_ONE;
          end else begin
            ovf_next = carry;
            cnt_next = CNT_TWO;
          end
        end
        LOADED: begin
          if (acc) begin
            ovf_next = ovf_reg | carry;
            cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;
          end else begin
            ovf_next = carry;
            cnt_next = CNT_TWO;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      y_reg     <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign y   = y_reg;
  assign ovf = ovf_reg;
  assign cnt = cnt_reg;

endmodule
